// File: rtl/soc_multi_timer.sv
// soc_multi_timer: NUM_CH independent prescaled down-counters with snapshot,
// one-shot/continuous mode and per-channel level interrupts on an Avalon-MM slave.
module soc_multi_timer #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 32,
  parameter int PRE_W     = 8,
  parameter int RESET_PER = 49999,
  localparam int AW       = $clog2(NUM_CH) + 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [AW-1:0]     address,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] irq_ch,
  output logic              irq
);

  localparam logic [2:0]       REG_STATUS   = 3'd0;
  localparam logic [2:0]       REG_CONTROL  = 3'd1;
  localparam logic [2:0]       REG_PERIOD   = 3'd2;
  localparam logic [2:0]       REG_SNAP     = 3'd3;
  localparam logic [2:0]       REG_PRESCALE = 3'd4;
  localparam logic [CNT_W-1:0] RST_CNT      = CNT_W'(RESET_PER);

  logic              wr;
  logic [AW-1:0]     ch_sel;
  logic [2:0]        reg_sel;
  logic              start_bit;
  logic              stop_bit;

  logic [NUM_CH-1:0] wr_status;
  logic [NUM_CH-1:0] wr_ctrl;
  logic [NUM_CH-1:0] wr_per;
  logic [NUM_CH-1:0] wr_snap;
  logic [NUM_CH-1:0] wr_pre;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] tmo;
  logic [NUM_CH-1:0] pclr;

  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];
  logic [CNT_W-1:0]  per_q  [NUM_CH];
  logic [CNT_W-1:0]  per_d  [NUM_CH];
  logic [CNT_W-1:0]  snap_q [NUM_CH];
  logic [CNT_W-1:0]  snap_d [NUM_CH];
  logic [PRE_W-1:0]  pre_q  [NUM_CH];
  logic [PRE_W-1:0]  pre_d  [NUM_CH];
  logic [PRE_W-1:0]  pcnt_q [NUM_CH];
  logic [PRE_W-1:0]  pcnt_d [NUM_CH];
  logic [NUM_CH-1:0] run_q;
  logic [NUM_CH-1:0] run_d;
  logic [NUM_CH-1:0] to_q;
  logic [NUM_CH-1:0] to_d;
  logic [NUM_CH-1:0] ito_q;
  logic [NUM_CH-1:0] ito_d;
  logic [NUM_CH-1:0] cont_q;
  logic [NUM_CH-1:0] cont_d;
  logic [31:0]       rd_q;
  logic [31:0]       rd_d;

  assign wr        = chipselect & ~write_n;
  assign ch_sel    = address >> 3;
  assign reg_sel   = address[2:0];
  assign start_bit = writedata[2];
  assign stop_bit  = writedata[3];

  // Channel indices at or above NUM_CH never match, so those writes fall away.
  always_comb begin
    wr_status = '0;
    wr_ctrl   = '0;
    wr_per    = '0;
    wr_snap   = '0;
    wr_pre    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr && (ch_sel == AW'(i))) begin
        case (reg_sel)
          REG_STATUS:   wr_status[i] = 1'b1;
          REG_CONTROL:  wr_ctrl[i]   = 1'b1;
          REG_PERIOD:   wr_per[i]    = 1'b1;
          REG_SNAP:     wr_snap[i]   = 1'b1;
          REG_PRESCALE: wr_pre[i]    = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // A PERIOD write forces a reload, which takes precedence over a coincident timeout.
  always_comb begin
    tick = '0;
    tmo  = '0;
    pclr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      tick[i] = run_q[i] && (pcnt_q[i] == pre_q[i]);
      tmo[i]  = tick[i] && (cnt_q[i] == '0) && !wr_per[i];
      pclr[i] = (wr_ctrl[i] && (start_bit || stop_bit)) || wr_per[i] || wr_pre[i];
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    per_d  = per_q;
    snap_d = snap_q;
    pre_d  = pre_q;
    pcnt_d = pcnt_q;
    run_d  = run_q;
    to_d   = to_q;
    ito_d  = ito_q;
    cont_d = cont_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_per[i]) begin
        per_d[i] = writedata[CNT_W-1:0];
        cnt_d[i] = writedata[CNT_W-1:0];
      end else if (tick[i]) begin
        cnt_d[i] = (cnt_q[i] == '0) ? per_q[i] : cnt_q[i] - CNT_W'(1);
      end

      if (pclr[i] || tick[i]) begin
        pcnt_d[i] = '0;
      end else if (run_q[i]) begin
        pcnt_d[i] = pcnt_q[i] + PRE_W'(1);
      end

      // START beats STOP in the same write; one-shot timeout halts the channel.
      if (wr_per[i]) begin
        run_d[i] = 1'b0;
      end else if (wr_ctrl[i] && start_bit) begin
        run_d[i] = 1'b1;
      end else if (wr_ctrl[i] && stop_bit) begin
        run_d[i] = 1'b0;
      end else if (tmo[i] && !cont_q[i]) begin
        run_d[i] = 1'b0;
      end

      // A timeout on the same edge as a clear wins so no event is lost.
      if (tmo[i]) begin
        to_d[i] = 1'b1;
      end else if (wr_status[i]) begin
        to_d[i] = 1'b0;
      end

      if (wr_ctrl[i]) begin
        ito_d[i]  = writedata[0];
        cont_d[i] = writedata[1];
      end
      if (wr_snap[i]) begin
        snap_d[i] = cnt_q[i];
      end
      if (wr_pre[i]) begin
        pre_d[i] = writedata[PRE_W-1:0];
      end
    end
  end

  always_comb begin
    rd_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == AW'(i)) begin
        case (reg_sel)
          REG_STATUS:   rd_d[1:0]       = {run_q[i], to_q[i]};
          REG_CONTROL:  rd_d[1:0]       = {cont_q[i], ito_q[i]};
          REG_PERIOD:   rd_d[CNT_W-1:0] = per_q[i];
          REG_SNAP:     rd_d[CNT_W-1:0] = snap_q[i];
          REG_PRESCALE: rd_d[PRE_W-1:0] = pre_q[i];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= RST_CNT;
        per_q[i]  <= RST_CNT;
        snap_q[i] <= '0;
        pre_q[i]  <= '0;
        pcnt_q[i] <= '0;
      end
      run_q  <= '0;
      to_q   <= '0;
      ito_q  <= '0;
      cont_q <= '0;
      rd_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      snap_q <= snap_d;
      pre_q  <= pre_d;
      pcnt_q <= pcnt_d;
      run_q  <= run_d;
      to_q   <= to_d;
      ito_q  <= ito_d;
      cont_q <= cont_d;
      rd_q   <= rd_d;
    end
  end

  assign readdata = rd_q;
  assign irq_ch   = to_q & ito_q;
  assign irq      = |irq_ch;

endmodule

// File: tb/tb_soc_multi_timer.sv
// Self-checking bench for soc_multi_timer: default 4-channel instance plus a
// 3-channel, 16-bit instance for out-of-range channel and reset truncation.
module tb_soc_multi_timer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        chipselect;
  logic        write_n;
  logic [4:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  irq_ch;
  logic        irq;

  logic        cs3;
  logic        wn3;
  logic [4:0]  addr3;
  logic [31:0] wd3;
  logic [31:0] rd3;
  logic [2:0]  irq_ch3;
  logic        irq3;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  soc_multi_timer dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .write_n(write_n),
    .address(address), .writedata(writedata), .readdata(readdata),
    .irq_ch(irq_ch), .irq(irq)
  );

  soc_multi_timer #(.NUM_CH(3), .CNT_W(16), .PRE_W(4), .RESET_PER(70000)) dut3 (
    .clk(clk), .reset_n(reset_n), .chipselect(cs3), .write_n(wn3),
    .address(addr3), .writedata(wd3), .readdata(rd3),
    .irq_ch(irq_ch3), .irq(irq3)
  );

  task automatic bus_write(input int ch, input int rg, input logic [31:0] data);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0;
    address = {ch[1:0], rg[2:0]}; writedata = data;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input int ch, input int rg, output logic [31:0] data);
    @(negedge clk);
    address = {ch[1:0], rg[2:0]};
    @(negedge clk);
    data = readdata;
  endtask

  task automatic wr3(input int ch, input int rg, input logic [31:0] data);
    @(negedge clk);
    cs3 = 1'b1; wn3 = 1'b0; addr3 = {ch[1:0], rg[2:0]}; wd3 = data;
    @(negedge clk);
    cs3 = 1'b0; wn3 = 1'b1;
  endtask

  task automatic rdd3(input int ch, input int rg, output logic [31:0] data);
    @(negedge clk);
    addr3 = {ch[1:0], rg[2:0]};
    @(negedge clk);
    data = rd3;
  endtask

  // Returns the edge count at which irq_ch[ch] is first seen high, or -1.
  task automatic wait_irq(input int ch, input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      if (irq_ch[ch]) begin
        at = cyc;
        return;
      end
      @(negedge clk);
    end
  endtask

  // Counter value just before edge e for a channel started at edge st.
  function automatic int model_cnt(input int p, input int pre, input int st, input int e);
    int ticks;
    ticks = (e - st - 1) / (pre + 1);
    return p - (ticks % (p + 1));
  endfunction

  task automatic test_reset;
    logic [31:0] d;
    reset_n = 1'b0;
    chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    cs3 = 1'b0; wn3 = 1'b1; addr3 = '0; wd3 = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    n_checks++; if (irq_ch !== 4'b0) begin n_fail++; $display("FAIL reset_irq_ch: got %b expected 0", irq_ch); end
    n_checks++; if (readdata !== 32'd0) begin n_fail++; $display("FAIL reset_readdata: got %0d expected 0", readdata); end
    reset_n = 1'b1;
    bus_read(0, 2, d);
    n_checks++; if (d !== 32'd49999) begin n_fail++; $display("FAIL reset_period: got %0d expected 49999", d); end
    for (int r = 0; r < 8; r++) begin
      if (r == 2) continue;
      bus_read(0, r, d);
      n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_reg%0d: got %0d expected 0", r, d); end
    end
    rdd3(2, 2, d);
    n_checks++; if (d !== 32'(70000 % 65536)) begin n_fail++; $display("FAIL reset_trunc: got %0d expected %0d", d, 70000 % 65536); end
  endtask

  task automatic test_continuous;
    logic [31:0] d;
    int st, at;
    bus_write(1, 2, 32'd9);
    bus_write(1, 4, 32'd0);
    bus_write(1, 1, 32'h7);
    st = cyc;
    for (int k = 1; k <= 3; k++) begin
      wait_irq(1, 40, at);
      n_checks++; if (at !== st + 10 * k) begin n_fail++; $display("FAIL cont_to_time%0d: got %0d expected %0d", k, at, st + 10 * k); end
      bus_read(1, 0, d);
      n_checks++; if (d !== 32'd3) begin n_fail++; $display("FAIL cont_status%0d: got %0d expected 3", k, d); end
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL cont_irq_held%0d: got %b expected 1", k, irq); end
      bus_write(1, 0, 32'd0);
      n_checks++; if (irq_ch[1] !== 1'b0) begin n_fail++; $display("FAIL cont_irq_clear%0d: got %b expected 0", k, irq_ch[1]); end
    end
    bus_write(1, 1, 32'h8);
    bus_write(1, 0, 32'd0);
  endtask

  task automatic test_one_shot;
    logic [31:0] d;
    int st, at, rises;
    bus_write(2, 2, 32'd3);
    bus_write(2, 4, 32'd4);
    bus_write(2, 1, 32'h5);
    st = cyc;
    wait_irq(2, 60, at);
    n_checks++; if (at !== st + 20) begin n_fail++; $display("FAIL oneshot_time: got %0d expected %0d", at, st + 20); end
    bus_read(2, 0, d);
    n_checks++; if (d !== 32'd1) begin n_fail++; $display("FAIL oneshot_status: got %0d expected 1", d); end
    bus_write(2, 3, 32'd0);
    bus_read(2, 3, d);
    n_checks++; if (d !== 32'd3) begin n_fail++; $display("FAIL oneshot_counter: got %0d expected 3", d); end
    bus_write(2, 0, 32'd0);
    rises = 0;
    repeat (100) begin
      @(negedge clk);
      if (irq_ch[2]) rises++;
    end
    n_checks++; if (rises !== 0) begin n_fail++; $display("FAIL oneshot_quiet: got %0d cycles with irq expected 0", rises); end
  endtask

  task automatic test_clear_collision;
    logic [31:0] d;
    int st;
    bus_write(1, 2, 32'd19);
    bus_write(1, 1, 32'h7);
    st = cyc;
    while (cyc < st + 18) @(negedge clk);
    bus_write(1, 0, 32'd0);
    bus_read(1, 0, d);
    n_checks++; if (d !== 32'd3) begin n_fail++; $display("FAIL collide_status: got %0d expected 3", d); end
    bus_write(1, 0, 32'd0);
    bus_read(1, 0, d);
    n_checks++; if (d !== 32'd2) begin n_fail++; $display("FAIL collide_cleared: got %0d expected 2", d); end
    bus_write(1, 1, 32'h8);
    bus_write(1, 0, 32'd0);
  endtask

  task automatic test_simultaneous;
    logic [31:0] d;
    logic [3:0] exp_v;
    int s0, s3, t0, t3, tmin, at;
    bus_write(0, 2, 32'd7);
    bus_write(0, 4, 32'd0);
    bus_write(3, 2, 32'd5);
    bus_write(3, 4, 32'd0);
    bus_write(0, 1, 32'h5);
    s0 = cyc;
    bus_write(3, 1, 32'h5);
    s3 = cyc;
    t0 = s0 + 8;
    t3 = s3 + 6;
    tmin = (t0 < t3) ? t0 : t3;
    at = -1;
    for (int k = 0; k < 40; k++) begin
      if (irq) begin at = cyc; break; end
      @(negedge clk);
    end
    exp_v = '0;
    if (t0 == tmin) exp_v[0] = 1'b1;
    if (t3 == tmin) exp_v[3] = 1'b1;
    n_checks++; if (at !== tmin) begin n_fail++; $display("FAIL simul_time: got %0d expected %0d", at, tmin); end
    n_checks++; if (irq_ch !== exp_v) begin n_fail++; $display("FAIL simul_vector: got %b expected %b", irq_ch, exp_v); end
    repeat (10) @(negedge clk);
    n_checks++; if (irq_ch !== 4'b1001) begin n_fail++; $display("FAIL simul_both: got %b expected 1001", irq_ch); end
    bus_write(0, 0, 32'd0);
    bus_write(3, 0, 32'd0);
    bus_read(3, 0, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL simul_clear: got %0d expected 0", d); end
  endtask

  task automatic test_random;
    logic [31:0] d;
    int ch, p, s, cont, len, st, at;
    for (int it = 0; it < 8; it++) begin
      ch = $urandom_range(0, 3);
      p = $urandom_range(4, 15);
      s = $urandom_range(0, 3);
      cont = $urandom_range(0, 1);
      len = (p + 1) * (s + 1);
      bus_write(ch, 2, 32'(p));
      bus_write(ch, 4, 32'(s));
      bus_write(ch, 1, 32'(5 | (cont << 1)));
      st = cyc;
      wait_irq(ch, len + 10, at);
      n_checks++; if (at !== st + len) begin n_fail++; $display("FAIL rand_to ch%0d p%0d s%0d: got %0d expected %0d", ch, p, s, at, st + len); end
      bus_read(ch, 0, d);
      n_checks++; if (d !== 32'(cont ? 3 : 1)) begin n_fail++; $display("FAIL rand_status ch%0d: got %0d expected %0d", ch, d, cont ? 3 : 1); end
      if (cont != 0) begin
        bus_write(ch, 0, 32'd0);
        wait_irq(ch, len + 10, at);
        n_checks++; if (at !== st + 2 * len) begin n_fail++; $display("FAIL rand_to2 ch%0d: got %0d expected %0d", ch, at, st + 2 * len); end
      end else begin
        bus_write(ch, 3, 32'd0);
        bus_read(ch, 3, d);
        n_checks++; if (d !== 32'(p)) begin n_fail++; $display("FAIL rand_hold ch%0d: got %0d expected %0d", ch, d, p); end
      end
      bus_write(ch, 1, 32'h8);
      bus_write(ch, 0, 32'd0);
      bus_read(ch, 0, d);
      n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL rand_idle ch%0d: got %0d expected 0", ch, d); end
    end
  endtask

  task automatic test_snap_period;
    logic [31:0] d;
    int st, pre, dly, e;
    pre = $urandom_range(0, 2);
    dly = $urandom_range(50, 150);
    bus_write(0, 2, 32'd7);
    bus_write(3, 2, 32'd1000);
    bus_write(3, 4, 32'(pre));
    bus_write(3, 1, 32'h4);
    st = cyc;
    while (cyc < st + dly) @(negedge clk);
    bus_write(3, 3, 32'hDEAD);
    e = cyc;
    bus_read(3, 3, d);
    n_checks++; if (d !== 32'(model_cnt(1000, pre, st, e))) begin n_fail++; $display("FAIL snap_value: got %0d expected %0d", d, model_cnt(1000, pre, st, e)); end
    bus_read(0, 2, d);
    n_checks++; if (d !== 32'd7) begin n_fail++; $display("FAIL snap_other_period: got %0d expected 7", d); end
    bus_read(0, 0, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL snap_other_status: got %0d expected 0", d); end
    bus_read(3, 0, d);
    n_checks++; if (d !== 32'd2) begin n_fail++; $display("FAIL snap_running: got %0d expected 2", d); end
    bus_write(3, 2, 32'd50);
    bus_read(3, 0, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL period_stops: got %0d expected 0", d); end
    repeat (10) @(negedge clk);
    bus_write(3, 3, 32'd0);
    bus_read(3, 3, d);
    n_checks++; if (d !== 32'd50) begin n_fail++; $display("FAIL period_reload: got %0d expected 50", d); end
  endtask

  task automatic test_bad_channel;
    logic [31:0] d;
    wr3(3, 2, 32'h1234);
    wr3(3, 4, 32'h3);
    wr3(3, 1, 32'h7);
    repeat (20) @(negedge clk);
    for (int r = 0; r < 5; r++) begin
      rdd3(3, r, d);
      n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL badch_read%0d: got %0d expected 0", r, d); end
    end
    for (int c = 0; c < 3; c++) begin
      rdd3(c, 2, d);
      n_checks++; if (d !== 32'(70000 % 65536)) begin n_fail++; $display("FAIL badch_period%0d: got %0d expected %0d", c, d, 70000 % 65536); end
      rdd3(c, 0, d);
      n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL badch_status%0d: got %0d expected 0", c, d); end
    end
    n_checks++; if (irq_ch3 !== 3'b0 || irq3 !== 1'b0) begin n_fail++; $display("FAIL badch_irq: got %b/%b expected 000/0", irq_ch3, irq3); end
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] d;
    int st, at, rises;
    bus_write(0, 2, 32'd3);
    bus_write(0, 4, 32'd0);
    bus_write(0, 1, 32'h7);
    st = cyc;
    wait_irq(0, 20, at);
    n_checks++; if (at !== st + 4) begin n_fail++; $display("FAIL midrst_to: got %0d expected %0d", at, st + 4); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (irq_ch !== 4'b0 || irq !== 1'b0) begin n_fail++; $display("FAIL midrst_irq: got %b/%b expected 0000/0", irq_ch, irq); end
    n_checks++; if (readdata !== 32'd0) begin n_fail++; $display("FAIL midrst_readdata: got %0d expected 0", readdata); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus_read(0, 0, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL midrst_status: got %0d expected 0", d); end
    bus_read(0, 2, d);
    n_checks++; if (d !== 32'd49999) begin n_fail++; $display("FAIL midrst_period: got %0d expected 49999", d); end
    rises = 0;
    repeat (30) begin
      @(negedge clk);
      if (irq) rises++;
    end
    n_checks++; if (rises !== 0) begin n_fail++; $display("FAIL midrst_quiet: got %0d cycles with irq expected 0", rises); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_continuous;
    test_one_shot;
    test_clear_collision;
    test_simultaneous;
    test_random;
    test_snap_period;
    test_bad_channel;
    test_reset_mid_run;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
